// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// The loader turns a framed byte stream into 32-bit instruction-memory writes.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } state_t;

    // A length of zero, or one larger than the memory, is rejected.
    function automatic logic len_legal(input logic [7:0] len, input logic [7:0] depth);
        return (len != 8'd0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler for the loader.
// Bytes arrive most significant first; the fourth byte completes a word.
module imem_loader_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        last
);

    // Only the three oldest bytes need storing; the fourth is taken live.
    logic [23:0] word_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 24'd0;
            idx_q  <= 2'd0;
        end else if (clear) begin
            word_q <= 24'd0;
            idx_q  <= 2'd0;
        end else if (shift) begin
            word_q <= {word_q[15:0], data};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign word_next = {word_q, data};
    assign last      = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses sync/length/data frames and writes instruction memory,
// holding the CPU frozen for the duration of a load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | hunting for the sync byte, CPU running
// ST_LEN   | sync seen, waiting for the word count
// ST_DATA  | collecting the four bytes of the current word
// ST_WRITE | one-cycle memory write of the assembled word
// ST_DONE  | one-cycle completion pulse, then back to IDLE
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t              state_q, state_d;
    logic                started_q;
    logic [7:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic                err_q;

    logic                accept;
    logic                asm_clear;
    logic                asm_shift;
    logic                asm_last;
    logic [31:0]         asm_word;
    logic                len_ok;

    assign accept = in_valid & in_ready;
    assign len_ok = len_legal(in_data, DEPTH_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        done      = 1'b0;
        cpu_hold  = 1'b1;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // started_q keeps in_ready low while reset is asserted.
                in_ready = started_q;
                cpu_hold = 1'b0;
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                in_ready = 1'b1;
                if (accept) begin
                    asm_clear = 1'b1;
                    state_d   = len_ok ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                state_d = (cnt_q == 8'd1) ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cpu_hold = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            cnt_q     <= 8'd0;
            addr_q    <= '0;
            waddr_q   <= '0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if ((state_q == ST_IDLE) && accept && (in_data == SYNC_BYTE)) begin
                err_q <= 1'b0;
            end
            if ((state_q == ST_LEN) && accept) begin
                if (len_ok) begin
                    cnt_q  <= in_data;
                    addr_q <= '0;
                end else begin
                    err_q  <= 1'b1;
                end
            end
            // Write port registers load only when a word completes, so they
            // hold their last values between strobes.
            if ((state_q == ST_DATA) && accept && asm_last) begin
                waddr_q <= addr_q;
                wdata_q <= asm_word;
            end
            if (state_q == ST_WRITE) begin
                cnt_q <= cnt_q - 8'd1;
                if (cnt_q != 8'd1) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    imem_loader_asm u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (asm_clear),
        .shift     (asm_shift),
        .data      (in_data),
        .word_next (asm_word),
        .last      (asm_last)
    );

    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte streams are fed with optional
// random stalls and the observed writes are compared to a frame parser model.
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                done_cnt = 0;
    logic              prev_done = 1'b0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                exp_done;
    logic              m_err = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                got_addr.push_back(imem_waddr);
                got_data.push_back(imem_wdata);
                n_checks++;
                if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_handshake: in_ready=%b cpu_hold=%b, required 0/1", in_ready, cpu_hold);
                end
            end
            if (done) begin
                done_cnt++;
                n_checks++;
                if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || imem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_cycle: in_ready=%b cpu_hold=%b we=%b, required 0/1/0", in_ready, cpu_hold, imem_we);
                end
            end
            if (prev_done) begin
                n_checks++;
                if (cpu_hold !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_release: cpu_hold=%b after done, required 0", cpu_hold);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Frame parser: sync, length, then big-endian words at consecutive addresses.
    task automatic model(input logic [7:0] q[$]);
        int st, rem, k, addr;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        st = 0; rem = 0; k = 0; addr = 0; w = 32'd0;
        foreach (q[i]) begin
            if (st == 0) begin
                if (q[i] == 8'hA5) begin
                    m_err = 1'b0;
                    st = 1;
                end
            end else if (st == 1) begin
                if (q[i] == 8'd0 || int'(q[i]) > DEPTH) begin
                    m_err = 1'b1;
                    st = 0;
                end else begin
                    rem = int'(q[i]); addr = 0; k = 0; st = 2;
                end
            end else begin
                w = {w[23:0], q[i]};
                k++;
                if (k == 4) begin
                    exp_addr.push_back(ADDR_W'(addr));
                    exp_data.push_back(w);
                    addr++; rem--; k = 0;
                    if (rem == 0) begin
                        exp_done++;
                        st = 0;
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        bit ok;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted in 50 cycles, in_ready=%b", b, in_ready);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] q[$], input bit gaps);
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        model(q);
        foreach (q[i]) send_byte(q[i], gaps);
        repeat (5) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (got_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, required %0d", name, got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                n_checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got %0d:%h, required %0d:%h",
                             name, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        n_checks++;
        if (done_cnt != exp_done) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d, required %0d", name, done_cnt, exp_done);
        end
        n_checks++;
        if (err !== m_err || cpu_hold !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_state: err=%b cpu_hold=%b in_ready=%b, required %b/0/1",
                     name, err, cpu_hold, in_ready, m_err);
        end
        if (exp_addr.size() > 0) begin
            n_checks++;
            if (imem_waddr !== exp_addr[$] || imem_wdata !== exp_data[$]) begin
                n_fail++;
                $display("FAIL %s port_hold: got %0d:%h, required %0d:%h",
                         name, imem_waddr, imem_wdata, exp_addr[$], exp_data[$]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_waddr !== '0 || imem_wdata !== 32'd0 ||
            cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b we=%b addr=%0d data=%h hold=%b done=%b err=%b, required all 0",
                     name, in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err);
        end
    endtask

    function automatic logic [7:0] rand_data();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        m_err = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q = '{8'hA5, 8'h04, 8'h20, 8'h0A, 8'hFF, 8'hFD, 8'h1D, 8'h40, 8'h00, 8'h01,
              8'h21, 8'h4A, 8'h00, 8'h05, 8'h21, 8'h4A, 8'h00, 8'h06};
        run_frame("basic4", q, 1'b0);
        n_checks++;
        if (got_data.size() != 4 || got_data[0] !== 32'h200AFFFD || got_data[3] !== 32'h214A0006) begin
            n_fail++;
            $display("FAIL basic4_literal: got %0d words, required 200AFFFD..214A0006", got_data.size());
        end
    endtask

    task automatic test_discard();
        logic [7:0] q[$];
        q = '{8'h00, 8'h13, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("discard", q, 1'b0);
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'hDEADBEEF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_literal: words=%0d err=%b, required 1 DEADBEEF err 0", got_data.size(), err);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] q[$];
        q = '{8'hA5, 8'h00};
        run_frame("len_zero", q, 1'b0);
        q = '{8'hA5, 8'h21};
        run_frame("len_over", q, 1'b0);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_over_err: got %b, required 1", err);
        end
        q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        run_frame("err_clear", q, 1'b0);
    endtask

    task automatic test_gaps();
        logic [7:0] q[$];
        q = '{8'hA5, 8'h02};
        repeat (8) q.push_back(rand_data());
        run_frame("gaps_ref", q, 1'b0);
        run_frame("gaps_rand", q, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q[$];
        logic [31:0] w0;
        got_addr.delete();
        got_data.delete();
        q = '{8'hA5, 8'h02};
        repeat (6) q.push_back(rand_data());
        w0 = {q[2], q[3], q[4], q[5]};
        foreach (q[i]) send_byte(q[i], 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_err = 1'b0;
        n_checks++;
        if (got_addr.size() != 1 || got_addr[0] !== '0 || got_data[0] !== w0) begin
            n_fail++;
            $display("FAIL abort_writes: got %0d writes, required 1 at addr0 data %h", got_addr.size(), w0);
        end
        @(posedge clk); #1;
        q = '{8'hA5, 8'h02};
        repeat (8) q.push_back(rand_data());
        run_frame("after_reset", q, 1'b1);
    endtask

    task automatic test_full_depth();
        logic [7:0] q[$];
        q = '{8'hA5, 8'h20};
        repeat (128) q.push_back(rand_data());
        run_frame("full_depth", q, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [7:0] q[$];
        logic [7:0] b;
        for (int f = 0; f < 6; f++) begin
            q.delete();
            repeat ($urandom_range(0, 3)) begin
                b = rand_data();
                if (b == 8'hA5) b = 8'h5A;
                q.push_back(b);
            end
            q.push_back(8'hA5);
            q.push_back(8'($urandom_range(1, 5)));
            repeat (4 * int'(q[$])) q.push_back(rand_data());
            run_frame($sformatf("random%0d", f), q, f[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_discard();
        test_bad_len();
        test_gaps();
        test_reset_mid_frame();
        test_full_depth();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
